// File: rtl/bucket_bitmap.sv
`default_nettype none
// ============================================================================
// bucket_bitmap : per-bucket occupancy counters with a registered non-zero
//                 bitmap, two-stage inc/dec pipeline and sweep-based clear.
// Revision      : 1.0
// ============================================================================
module bucket_bitmap #(
  parameter int WIDTH_LOG   = 4,
  parameter int WIDTH       = 1 << WIDTH_LOG,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_op,
  input  logic [WIDTH_LOG-1:0] in_index,
  output logic [WIDTH-1:0]     bitmap,
  output logic                 empty,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 init_done
);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] C_CNT_MAX  = '1;
  localparam logic [COUNT_WIDTH-1:0] C_CNT_ZERO = '0;
  localparam logic [WIDTH_LOG-1:0]   C_LAST_IDX = WIDTH_LOG'(WIDTH - 1);

  state_t                 state_q,     state_d;
  logic [WIDTH_LOG-1:0]   sweep_idx_q, sweep_idx_d;
  logic [WIDTH-1:0]       bitmap_q,    bitmap_d;
  logic                   empty_q,     empty_d;
  logic                   overflow_q,  overflow_d;
  logic                   underflow_q, underflow_d;
  logic                   s1_valid_q,  s1_valid_d;
  logic                   s1_op_q,     s1_op_d;
  logic [WIDTH_LOG-1:0]   s1_idx_q,    s1_idx_d;
  logic [COUNT_WIDTH-1:0] s1_cnt_q,    s1_cnt_d;

  logic [COUNT_WIDTH-1:0] count_mem [WIDTH];
  logic                   mem_we;
  logic [WIDTH_LOG-1:0]   mem_waddr;
  logic [COUNT_WIDTH-1:0] mem_wdata;

  logic                   accept;
  logic                   inc_sat;
  logic                   dec_sat;
  logic [COUNT_WIDTH-1:0] new_cnt;
  logic [COUNT_WIDTH-1:0] rd_cnt;

  assign in_ready  = (state_q == ST_READY) && !clear;
  assign init_done = (state_q == ST_READY);
  assign accept    = in_valid && in_ready;
  assign bitmap    = bitmap_q;
  assign empty     = empty_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Second stage: saturating update of the count captured by the first stage.
  always_comb begin
    inc_sat = !s1_op_q && (s1_cnt_q == C_CNT_MAX);
    dec_sat =  s1_op_q && (s1_cnt_q == C_CNT_ZERO);
    new_cnt = s1_cnt_q;
    if (s1_op_q) begin
      if (!dec_sat) new_cnt = s1_cnt_q - 1'b1;
    end else begin
      if (!inc_sat) new_cnt = s1_cnt_q + 1'b1;
    end
  end

  // The array write for the stage-2 command lands on the same edge the next
  // command reads, so a matching index must take the freshly computed count.
  assign rd_cnt = (s1_valid_q && (s1_idx_q == in_index)) ? new_cnt
                                                         : count_mem[in_index];

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    bitmap_d    = bitmap_q;
    empty_d     = empty_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    s1_valid_d  = accept;
    s1_op_d     = s1_op_q;
    s1_idx_d    = s1_idx_q;
    s1_cnt_d    = s1_cnt_q;
    mem_we      = 1'b0;
    mem_waddr   = sweep_idx_q;
    mem_wdata   = C_CNT_ZERO;

    if (accept) begin
      s1_op_d  = in_op;
      s1_idx_d = in_index;
      s1_cnt_d = rd_cnt;
    end

    case (state_q)
      ST_INIT: begin
        mem_we      = 1'b1;
        mem_waddr   = sweep_idx_q;
        mem_wdata   = C_CNT_ZERO;
        bitmap_d    = '0;
        empty_d     = 1'b1;
        if (clear) begin
          sweep_idx_d = '0;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
        end else if (sweep_idx_q == C_LAST_IDX) begin
          sweep_idx_d = '0;
          state_d     = ST_READY;
        end else begin
          sweep_idx_d = sweep_idx_q + 1'b1;
        end
      end
      ST_READY: begin
        if (clear) begin
          state_d     = ST_INIT;
          sweep_idx_d = '0;
          bitmap_d    = '0;
          empty_d     = 1'b1;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          s1_valid_d  = 1'b0;
        end else if (s1_valid_q) begin
          mem_we              = 1'b1;
          mem_waddr           = s1_idx_q;
          mem_wdata           = new_cnt;
          bitmap_d[s1_idx_q]  = (new_cnt != C_CNT_ZERO);
          empty_d             = (bitmap_d == '0);
          overflow_d          = overflow_q  | inc_sat;
          underflow_d         = underflow_q | dec_sat;
        end
      end
      default: begin
        state_d     = ST_INIT;
        sweep_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      sweep_idx_q <= '0;
      bitmap_q    <= '0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_op_q     <= 1'b0;
      s1_idx_q    <= '0;
      s1_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      bitmap_q    <= bitmap_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_idx_q    <= s1_idx_d;
      s1_cnt_q    <= s1_cnt_d;
    end
  end

  // Counter storage is deliberately unreset; the INIT sweep zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) count_mem[mem_waddr] <= mem_wdata;
  end

endmodule
`default_nettype wire

// File: doc/bucket_bitmap.md
BUCKET_BITMAP -- requirements
Module: bucket_bitmap

Interface
REQ-001 The module SHALL have parameter WIDTH_LOG, default 4, giving log2 of the bucket count.
REQ-002 The module SHALL have parameter WIDTH, fixed at 1 << WIDTH_LOG, giving the bucket count and bitmap width.
REQ-003 The module SHALL have parameter COUNT_WIDTH, default 8, giving the width of each per-bucket occupancy counter.
REQ-004 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 The module SHALL have port clear  input  1  synchronous soft clear; starts a re-initialisation sweep.
REQ-007 The module SHALL have port in_valid  input  1  command valid.
REQ-008 The module SHALL have port in_ready  output  1  command accepted when in_valid and in_ready are both high on a clock edge.
REQ-009 The module SHALL have port in_op  input  1  command type: 0 = increment, 1 = decrement.
REQ-010 The module SHALL have port in_index  input  WIDTH_LOG  target bucket.
REQ-011 The module SHALL have port bitmap  output  WIDTH  registered bit i high iff count[i] is non-zero; this feeds the first-set finder.
REQ-012 The module SHALL have port empty  output  1  registered; high iff bitmap is all-zero.
REQ-013 The module SHALL have port overflow  output  1  sticky error flag.
REQ-014 The module SHALL have port underflow  output  1  sticky error flag.
REQ-015 The module SHALL have port init_done  output  1  high in READY state.

Function
REQ-016 The module SHALL hold the counters in a WIDTH-entry array accessed by one read and one write per cycle; it SHALL NOT reset the whole array in one cycle.
REQ-017 The FSM SHALL have two states. INIT writes zero to entry sweep_idx, then increments sweep_idx, one entry per cycle, starting from 0. READY processes commands.
REQ-018 The FSM SHALL move from INIT to READY in the cycle after entry WIDTH-1 is written, so INIT lasts exactly WIDTH cycles.
REQ-019 While in INIT, bitmap SHALL be all-zero and empty SHALL be 1.
REQ-020 in_ready SHALL equal (state == READY) and not clear, computed combinationally.
REQ-021 The command pipeline SHALL have two stages. S1 (acceptance edge) registers op and index and reads the count. S2 (next edge) computes the new count, writes it back, and updates bitmap[index] and empty.
REQ-022 bitmap and empty SHALL reflect an accepted command on the second clock edge after acceptance.
REQ-023 One command per cycle SHALL be sustained, with no bubbles.
REQ-024 When S1 and S2 target the same index, the S2 result SHALL be forwarded to S1, so back-to-back commands on one bucket see correct counts.
REQ-025 Arithmetic SHALL be unsigned COUNT_WIDTH.
  - Increment at 2^COUNT_WIDTH-1: count saturates, overflow is set, bitmap is unchanged.
  - Decrement at 0: count stays 0, underflow is set, bitmap is unchanged.
REQ-026 bitmap[i] SHALL go 0 to 1 only on an increment from 0, and 1 to 0 only on a decrement from 1.
REQ-027 overflow and underflow SHALL clear only on reset or clear.
REQ-028 When clear is asserted in READY, the module SHALL:
  - discard any in-flight S1/S2 command without writeback;
  - zero bitmap and the error flags on the next edge;
  - set empty to 1;
  - enter INIT with sweep_idx = 0.
REQ-029 clear asserted during INIT SHALL restart the sweep at index 0.
REQ-030 When clear and in_valid are high in the same cycle, clear SHALL win and the command SHALL NOT be accepted.

Reset
REQ-031 Asserting rst_n low SHALL immediately force state=INIT, sweep_idx=0, bitmap=0, empty=1, overflow=0, underflow=0, init_done=0, pipeline valids=0, and therefore in_ready=0.
REQ-032 Reset assertion mid-pipeline SHALL drop all in-flight commands.
REQ-033 After rst_n deasserts, the module SHALL run the INIT sweep before accepting commands.
REQ-034 Counter array contents SHALL NOT be relied on until INIT completes.

Verification
REQ-035 Scenario 1: release reset (WIDTH=16) -> in_ready=0 for exactly 16 cycles, then in_ready=1 and init_done=1, with bitmap=0x0000 and empty=1 throughout.
REQ-036 Scenario 2: increment index 3, then index 3 again on the next cycle -> bitmap=0x0008 two edges after the first acceptance; then two decrements of index 3 -> bitmap=0x0000, empty=1, underflow=0.
REQ-037 Scenario 3: decrement index 5 at count 0 -> underflow=1 and stays 1; bitmap bit 5 stays 0.
REQ-038 Scenario 4: COUNT_WIDTH=2, four increments of index 0 back-to-back -> count saturates at 3, overflow=1, bitmap=0x0001.
REQ-039 Scenario 5: increment indices 1 and 15, then assert clear with in_valid=1 in the same cycle -> command not accepted, bitmap=0x0000 next edge, then a 16-cycle INIT.
REQ-040 Scenario 6: assert rst_n low while two commands are in flight -> outputs take reset values immediately, with no writeback observed after reset release.
